// File: rtl/header_assembler.sv
// header_assembler: collects UART bytes into a block header and hands it off with valid/ack.
module header_assembler #(
  parameter int HEADER_BYTES = 80,
  parameter int TIMEOUT      = 500000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                rx_byte,
  input  logic                      rx_valid,
  input  logic                      header_ack,
  output logic [8*HEADER_BYTES-1:0] header,
  output logic                      header_valid,
  output logic                      busy,
  output logic [31:0]               byte_count,
  output logic                      timeout_err,
  output logic                      overrun
);
  localparam int W  = 8 * HEADER_BYTES;
  localparam int GW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t         state_q;
  logic [6:0]     idx_q;
  logic [GW-1:0]  gap_q;
  logic [W-1:0]   shift_q, shift_d, header_q;
  logic [31:0]    byte_count_q;
  logic           header_valid_q, timeout_err_q, overrun_q, done_d;
  always_comb begin
    shift_d = {shift_q[W-9:0], rx_byte};
    done_d  = (state_q == RECV) && rx_valid && (idx_q == 7'(HEADER_BYTES - 1));
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      gap_q          <= '0;
      shift_q        <= '0;
      header_q       <= '0;
      header_valid_q <= 1'b0;
      byte_count_q   <= '0;
      timeout_err_q  <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      timeout_err_q <= 1'b0;
      if (rx_valid) begin
        shift_q      <= shift_d;
        byte_count_q <= byte_count_q + 32'd1;
        gap_q        <= '0;
      end
      // a completing frame beats a coincident ack
      if (done_d) begin
        header_q       <= shift_d;
        header_valid_q <= 1'b1;
        if (header_valid_q && !header_ack) overrun_q <= 1'b1;
      end else if (header_ack) begin
        header_valid_q <= 1'b0;
      end
      if (state_q == IDLE) begin
        if (rx_valid) begin
          idx_q   <= 7'd1;
          state_q <= RECV;
        end
      end else if (rx_valid) begin
        idx_q   <= done_d ? 7'd0 : idx_q + 7'd1;
        state_q <= done_d ? IDLE : RECV;
      end else if (gap_q == GW'(TIMEOUT - 1)) begin
        gap_q         <= '0;
        idx_q         <= '0;
        state_q       <= IDLE;
        timeout_err_q <= 1'b1;
      end else begin
        gap_q <= gap_q + 1'b1;
      end
    end
  end
  assign header       = header_q;
  assign header_valid = header_valid_q;
  assign busy         = (state_q == RECV);
  assign byte_count   = byte_count_q;
  assign timeout_err  = timeout_err_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_header_assembler.sv
// tb_header_assembler: randomized frames checked against a queue-based frame model.
module tb_header_assembler;
  localparam int NB = 80;
  localparam int TO = 16;
  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     rx_byte = '0;
  logic           rx_valid = 1'b0;
  logic           header_ack = 1'b0;
  logic [639:0]   header;
  logic           header_valid, busy, timeout_err, overrun;
  logic [31:0]    byte_count;
  int pass_cnt = 0;
  int total = 0;
  logic [7:0]   frame[$];
  logic [639:0] m_header;
  logic         m_valid, m_over, m_terr;
  logic [31:0]  m_count;
  int           m_gap;
  header_assembler #(.HEADER_BYTES(NB), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .header_ack(header_ack), .header(header), .header_valid(header_valid),
    .busy(busy), .byte_count(byte_count), .timeout_err(timeout_err), .overrun(overrun)
  );
  always #5 clock = ~clock;
  task automatic model_clear();
    frame.delete();
    m_header = '0; m_valid = 0; m_over = 0; m_terr = 0; m_count = 0; m_gap = 0;
  endtask
  task automatic do_reset();
    rx_valid = 0; header_ack = 0; reset = 0;
    #3;
    @(posedge clock); #1;
    reset = 1;
    model_clear();
  endtask
  task automatic step(input logic v, input logic [7:0] b, input logic ack);
    bit done;
    rx_valid = v; rx_byte = b; header_ack = ack;
    @(posedge clock); #1;
    rx_valid = 0; header_ack = 0;
    m_terr = 0; done = 0;
    if (v) begin
      m_count++; m_gap = 0;
      frame.push_back(b);
      if (frame.size() == NB) begin
        for (int i = 0; i < NB; i++) m_header[639-8*i -: 8] = frame[i];
        if (m_valid && !ack) m_over = 1;
        m_valid = 1; done = 1;
        frame.delete();
      end
    end else if (frame.size() > 0) begin
      m_gap++;
      if (m_gap == TO) begin
        frame.delete(); m_gap = 0; m_terr = 1;
      end
    end
    if (!done && ack) m_valid = 0;
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (header !== '0) $display("FAIL reset_header act=%h exp=0", header); else pass_cnt++;
    total++; if (header_valid !== 1'b0) $display("FAIL reset_valid act=%b exp=0", header_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy act=%b exp=0", busy); else pass_cnt++;
    total++; if (byte_count !== 32'd0) $display("FAIL reset_count act=%0d exp=0", byte_count); else pass_cnt++;
    total++; if ({timeout_err, overrun} !== 2'b00) $display("FAIL reset_flags act=%b exp=00", {timeout_err, overrun}); else pass_cnt++;
  endtask
  task automatic test_frame();
    do_reset();
    for (int i = 0; i < NB; i++) begin
      step(1, 8'(i), 0);
      if (i == 0) begin
        total++; if (busy !== 1'b1) $display("FAIL busy_rise act=%b exp=1", busy); else pass_cnt++;
      end
    end
    total++; if (header[639:632] !== 8'h00) $display("FAIL first_byte act=%h exp=00", header[639:632]); else pass_cnt++;
    total++; if (header[7:0] !== 8'h4F) $display("FAIL last_byte act=%h exp=4f", header[7:0]); else pass_cnt++;
    total++; if (header !== m_header) $display("FAIL frame_header act=%h exp=%h", header, m_header); else pass_cnt++;
    total++; if (header_valid !== 1'b1) $display("FAIL frame_valid act=%b exp=1", header_valid); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL frame_busy act=%b exp=0", busy); else pass_cnt++;
    total++; if (byte_count !== 32'd80) $display("FAIL frame_count act=%0d exp=80", byte_count); else pass_cnt++;
    step(0, 0, 1);
    total++; if (header_valid !== 1'b0) $display("FAIL ack_clear act=%b exp=0", header_valid); else pass_cnt++;
    step(0, 0, 1);
    total++; if ({header_valid, overrun} !== 2'b00) $display("FAIL idle_ack act=%b exp=00", {header_valid, overrun}); else pass_cnt++;
  endtask
  task automatic test_timeout();
    int pulses = 0;
    logic [639:0] old;
    do_reset();
    for (int i = 0; i < NB; i++) step(1, 8'($urandom), 0);
    step(0, 0, 1);
    old = header;
    for (int i = 0; i < 10; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < TO + 6; i++) begin
      step(0, 0, 0);
      pulses += timeout_err;
      total++; if (timeout_err !== m_terr) $display("FAIL timeout_pulse cyc=%0d act=%b exp=%b", i, timeout_err, m_terr); else pass_cnt++;
    end
    total++; if (pulses != 1) $display("FAIL timeout_count act=%0d exp=1", pulses); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL timeout_busy act=%b exp=0", busy); else pass_cnt++;
    total++; if (header !== old) $display("FAIL timeout_header act=%h exp=%h", header, old); else pass_cnt++;
    total++; if (byte_count !== m_count) $display("FAIL timeout_bytes act=%0d exp=%0d", byte_count, m_count); else pass_cnt++;
    for (int i = 0; i < NB; i++) step(1, 8'($urandom), 0);
    total++; if (header !== m_header || header_valid !== 1'b1) $display("FAIL after_timeout act=%h/%b exp=%h/1", header, header_valid, m_header); else pass_cnt++;
  endtask
  task automatic test_gap();
    int pulses = 0;
    do_reset();
    for (int i = 0; i < NB; i++) begin
      step(1, 8'($urandom), 0);
      if (i != NB - 1) for (int j = 0; j < TO - 1; j++) begin
        step(0, 0, 0);
        pulses += timeout_err;
      end
    end
    total++; if (pulses != 0) $display("FAIL gap_timeout act=%0d exp=0", pulses); else pass_cnt++;
    total++; if (header !== m_header || header_valid !== 1'b1) $display("FAIL gap_frame act=%h/%b exp=%h/1", header, header_valid, m_header); else pass_cnt++;
  endtask
  task automatic test_overrun();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      for (int i = 0; i < 2 * NB; i++) step(1, 8'($urandom), (k == 1) && (i == 2 * NB - 1));
      total++; if (overrun !== m_over) $display("FAIL overrun_%0d act=%b exp=%b", k, overrun, m_over); else pass_cnt++;
      total++; if (header !== m_header) $display("FAIL overrun_header_%0d act=%h exp=%h", k, header, m_header); else pass_cnt++;
      total++; if (header_valid !== 1'b1) $display("FAIL overrun_valid_%0d act=%b exp=1", k, header_valid); else pass_cnt++;
    end
  endtask
  task automatic test_back_to_back();
    int errs = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic v;
      v = ($urandom_range(0, 99) < ((c % 500) < 450 ? 85 : 3));
      step(v, 8'($urandom), $urandom_range(0, 7) == 0);
      if (header !== m_header || header_valid !== m_valid || busy !== (frame.size() > 0) ||
          byte_count !== m_count || timeout_err !== m_terr || overrun !== m_over) begin
        if (errs < 5) $display("FAIL b2b cyc=%0d act=%b%b%b%b cnt=%0d exp=%b%b%b%b cnt=%0d", c,
          header_valid, busy, timeout_err, overrun, byte_count,
          m_valid, frame.size() > 0, m_terr, m_over, m_count);
        errs++;
      end
    end
    total++; if (errs != 0) $display("FAIL b2b_total act=%0d exp=0", errs); else pass_cnt++;
  endtask
  task automatic test_reset_midframe();
    logic [639:0] all_a5;
    do_reset();
    for (int i = 0; i < NB; i++) step(1, 8'($urandom), 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 0);
    reset = 0;
    #2;
    total++; if ({header_valid, busy, timeout_err, overrun} !== 4'b0 || header !== '0 || byte_count !== 0)
      $display("FAIL async_reset act=%b%b%b%b cnt=%0d exp=0000 cnt=0", header_valid, busy, timeout_err, overrun, byte_count);
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1;
    model_clear();
    for (int i = 0; i < NB; i++) step(1, 8'hA5, 0);
    all_a5 = {80{8'hA5}};
    total++; if (header !== all_a5) $display("FAIL post_reset_header act=%h exp=%h", header, all_a5); else pass_cnt++;
    total++; if (byte_count !== 32'd80) $display("FAIL post_reset_count act=%0d exp=80", byte_count); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_frame();
    test_timeout();
    test_gap();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/header_assembler.md
# header_assembler

Serial-side framing stage sitting directly upstream of the mining controller. It collects the byte stream delivered by the UART receiver into a complete 80-byte (640-bit) block header. It publishes the header, with a valid/ack handshake, to the block that loads it into the SHA-256 miner. It also reports reception activity (`busy`) so the top level can hold the processor in reset while a new header is arriving.

## Interface
Parameters:
- `HEADER_BYTES`, 80: bytes per frame. Output width is fixed at 640 bits; the bench may only shrink this for debug.
- `TIMEOUT`, 500000: maximum idle cycles between bytes inside a frame (10 ms at 50 MHz). Must be ≥ 2.

Ports:
- `clock`  in  1: single clock (UART domain, 50 MHz); all logic on rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserted at 0).
- `rx_byte`  in  8: received byte, qualified by `rx_valid`.
- `rx_valid`  in  1: one-cycle strobe per received byte.
- `header_ack`  in  1: consumer has taken `header`; clears `header_valid`.
- `header`  out  640: last complete frame. First byte received is at [639:632], last byte at [7:0] (nonce = [31:0]).
- `header_valid`  out  1: a completed frame is pending.
- `busy`  out  1: high while a frame is partially received.
- `byte_count`  out  32: total bytes accepted since reset; wraps modulo 2^32.
- `timeout_err`  out  1: one-cycle pulse when a partial frame is discarded.
- `overrun`  out  1: sticky; a frame completed while the previous one was unacknowledged.

## Operation
- Internal 640-bit shift register `shift` is separate from the `header` output register, so a partial frame never disturbs `header`.
- On each accepted byte: `shift <= {shift[631:0], rx_byte}`, `byte_count++`, `idx++`. `idx` is a 7-bit index 0..HEADER_BYTES-1.
- States:
  - IDLE: `busy` = 0. `rx_valid` → accept byte, `idx` = 1, go to RECV.
  - RECV: `busy` = 1.
    - `rx_valid` on the byte with `idx` = HEADER_BYTES-1 → `header <= {shift[631:0], rx_byte}`, `header_valid` = 1, `idx` = 0, go to IDLE.
    - Other `rx_valid` → accept, clear gap counter.
    - No `rx_valid` → gap counter++. When the counter reaches TIMEOUT: discard the partial frame (`idx` = 0, `shift` unchanged but ignored), pulse `timeout_err`, go to IDLE.
- Handshake:
  - `header_valid` stays high until a cycle with `header_ack` = 1.
  - Ack while `header_valid` = 0 is ignored.
- Completion while `header_valid` = 1 and `header_ack` = 0: `header` is overwritten, `header_valid` stays 1, `overrun` is set. It clears only on reset.
- Completion coinciding with `header_ack`: the new frame wins. `header_valid` stays 1, `overrun` is not set.
- Bytes that arrive during the timeout cycle: a byte with `rx_valid` on the cycle the counter would hit TIMEOUT is accepted and the counter clears, so no timeout fires.
- `byte_count` counts discarded bytes too.

## Timing
- Reset values (immediate on `reset` = 0, independent of clock):
  - State IDLE, `idx` = 0, gap counter = 0, `shift` = 0.
  - `header` = 0, `header_valid` = 0, `busy` = 0, `byte_count` = 0, `timeout_err` = 0, `overrun` = 0.
- Byte acceptance takes effect at the rising edge where `rx_valid` = 1. Outputs reflect it after that edge.
- Latency: `header` and `header_valid` update at the same edge that accepts the final byte, and are visible the following cycle. At that same edge `busy` drops.
- `busy` rises at the edge accepting the first byte of a frame.
- `timeout_err` is high for exactly one cycle: the cycle after the TIMEOUT-th consecutive idle cycle in RECV.
- Back-to-back `rx_valid` every cycle is supported with no throughput loss. A new frame may start on the cycle immediately after completion.
- Reset mid-frame discards all partial state. The first byte after reset release starts a new frame.

## Test plan
- Send 80 bytes 0x00..0x4F back-to-back:
  - After the last edge, `header[639:632]` = 0x00, `header[7:0]` = 0x4F, `header_valid` = 1, `busy` = 0, `byte_count` = 80.
  - Ack once → `header_valid` = 0 the next cycle.
- With TIMEOUT = 16, send 10 bytes then idle:
  - `timeout_err` pulses once after 16 idle cycles, `busy` = 0, `header` unchanged, `byte_count` = 10.
  - A following full 80-byte frame completes normally.
- With TIMEOUT = 16, send bytes separated by 15 idle cycles → no `timeout_err`, frame completes.
- Complete two frames without ack:
  - `overrun` = 1, `header` holds the second frame, `header_valid` = 1.
  - Repeat with `header_ack` asserted on the second frame's final-byte cycle → `overrun` stays 0, `header_valid` = 1.
- Assert `reset` = 0 after 40 bytes:
  - All outputs return to reset values immediately.
  - After release, 80 bytes 0xA5 → `header` = all 0xA5, `byte_count` = 80.
